status: RTL and testbench
=========================

// Module: status
// PURPOSE
//  Core FSM of the LED reaction game: lights a pseudo-random target pattern on led[9:0].
//  The player must raise exactly the matching switches before a level-dependent timeout.
//  Tracks level (1..MAX_LEVEL) and a 2-digit BCD score, both driven to 7-segment outputs.
//  Sits between the board switches/LEDs/HEX displays and the top-level wrapper.
// PARAMETERS
//  SHOW_CYCLES  16   cycles the target is shown before input is accepted
//  TIME_BASE    256  input timeout in cycles at level 1
//  TIME_STEP    16   timeout reduction per level above 1
//  MAX_LEVEL    9    last level; clearing it ends the game
// PORTS
//  clock      in   1   single clock, all logic on posedge
//  start      in   1   synchronous, active-high reset/restart
//  switch     in   10  player switches; switch[9] doubles as the game-begin key in IDLE
//  led        out  10  target pattern display
//  point_msb  out  7   score tens digit, 7-seg active-low {g,f,e,d,c,b,a}
//  point_lsb  out  7   score units digit, same encoding
//  level_out  out  7   current level digit, same encoding
//  splitter   out  1   separator segment: 0 in OVER, 1 in all other states
// BEHAVIOUR
//  Reset (start=1 at posedge): state=IDLE, level=1, score=00, count=0, led=0,
//    lfsr=10'h2A5. While start is held, every output stays at its reset value.
//  State register _current[3:0]; internal counter count[15:0]; level_in[3:0] holds the level.
//  lfsr: 10-bit Fibonacci LFSR, taps x^10+x^7+1, advances every cycle except during reset.
//  States:
//   0 OVER: led=0; terminal until start.
//   1 IDLE: led=0; switch[9]=1 -> RELEASE.
//   2 RELEASE: led=0; switch==0 -> LOAD.
//   3 LOAD: pattern<=lfsr, or 10'h001 if lfsr==0; count<=0; -> SHOW.
//   4 SHOW: led=pattern; count++; count==SHOW_CYCLES-1 -> INPUT with count<=0.
//   5 INPUT: led=pattern; count++. Checks, in priority order:
//     (a) (switch & ~pattern)!=0 -> OVER (wrong switch);
//     (b) switch==pattern -> SCORE;
//     (c) count==limit-1 -> OVER, where limit=TIME_BASE-(level-1)*TIME_STEP, minimum 8.
//   6 SCORE (1 cycle): score+=level in BCD, saturating at 99.
//     If level==MAX_LEVEL -> OVER, else level+1 -> RELEASE.
//  Codes 7..15 are illegal and go to OVER next cycle.
//  One state transition per cycle; all registered outputs update on the same posedge.
//  level_out shows level 1..9 (blank 7'h7F if out of range).
//  Segment codes: 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 (hex).
// TESTING
//  1 start=1 for 128 cycles -> _current=1, led=0, point_msb=point_lsb=7'h40, level_out=7'h79.
//  2 start=0, switch=10'h200 -> RELEASE(2); switch=0 -> LOAD(3), then SHOW(4) for 16 cycles,
//    led nonzero and constant.
//  3 In INPUT, drive switch=led -> SCORE then RELEASE; score=01, level_out=7'h24.
//  4 Repeat the full match every level -> after level 9, _current=0, score=45
//    (point_msb=7'h19, point_lsb=7'h12), splitter=0.
//  5 In INPUT, raise a switch outside the pattern -> OVER next cycle, score unchanged.
//  6 In INPUT at level 1, leave switch=0 -> OVER after exactly 256 cycles.
//    Then start=1 for 1 cycle -> IDLE, score=00.

Source files
------------

// File: rtl/status.sv
// Reaction-game core: shows an LFSR target on the LEDs, waits for the player to
// raise exactly those switches before a level-dependent timeout, and keeps a BCD score.
module status #(
   parameter int SHOW_CYCLES = 16,
   parameter int TIME_BASE   = 256,
   parameter int TIME_STEP   = 16,
   parameter int MAX_LEVEL   = 9
) (
   input  logic       clock,
   input  logic       start,
   input  logic [9:0] switch,
   output logic [9:0] led,
   output logic [6:0] point_msb,
   output logic [6:0] point_lsb,
   output logic [6:0] level_out,
   output logic       splitter
);

   typedef enum logic [3:0] {
      S_OVER    = 4'd0,
      S_IDLE    = 4'd1,
      S_RELEASE = 4'd2,
      S_LOAD    = 4'd3,
      S_SHOW    = 4'd4,
      S_INPUT   = 4'd5,
      S_SCORE   = 4'd6
   } state_e;

   state_e      _current, current_d;
   logic [15:0] count_q, count_d;
   logic [3:0]  level_in, level_d;
   logic [3:0]  tens_q, tens_d;
   logic [3:0]  ones_q, ones_d;
   logic [9:0]  pattern_q, pattern_d;
   logic [9:0]  lfsr_q, lfsr_next;
   logic [15:0] step_off, limit;
   logic [4:0]  ones_sum;

   function automatic logic [6:0] seg7(input logic [3:0] d);
      case (d)
         4'd0:    seg7 = 7'h40;
         4'd1:    seg7 = 7'h79;
         4'd2:    seg7 = 7'h24;
         4'd3:    seg7 = 7'h30;
         4'd4:    seg7 = 7'h19;
         4'd5:    seg7 = 7'h12;
         4'd6:    seg7 = 7'h02;
         4'd7:    seg7 = 7'h78;
         4'd8:    seg7 = 7'h00;
         4'd9:    seg7 = 7'h10;
         default: seg7 = 7'h7F;
      endcase
   endfunction

   // x^10 + x^7 + 1
   assign lfsr_next = {lfsr_q[8:0], lfsr_q[9] ^ lfsr_q[6]};

   // Timeout shrinks by TIME_STEP per level, floored at 8 cycles.
   assign step_off = 16'(level_in - 4'd1) * 16'(TIME_STEP);
   assign limit    = (16'(TIME_BASE) >= step_off + 16'd8) ? 16'(TIME_BASE) - step_off : 16'd8;
   assign ones_sum = {1'b0, ones_q} + {1'b0, level_in};

   always_comb begin
      current_d = _current;
      count_d   = count_q;
      level_d   = level_in;
      tens_d    = tens_q;
      ones_d    = ones_q;
      pattern_d = pattern_q;
      case (_current)
         S_OVER: current_d = S_OVER;
         S_IDLE: if (switch[9]) current_d = S_RELEASE;
         S_RELEASE: if (switch == 10'd0) current_d = S_LOAD;
         S_LOAD: begin
            pattern_d = (lfsr_q == 10'd0) ? 10'h001 : lfsr_q;
            count_d   = 16'd0;
            current_d = S_SHOW;
         end
         S_SHOW: begin
            if (count_q == 16'(SHOW_CYCLES - 1)) begin
               count_d   = 16'd0;
               current_d = S_INPUT;
            end else begin
               count_d = count_q + 16'd1;
            end
         end
         S_INPUT: begin
            count_d = count_q + 16'd1;
            if ((switch & ~pattern_q) != 10'd0)  current_d = S_OVER;
            else if (switch == pattern_q)        current_d = S_SCORE;
            else if (count_q == limit - 16'd1)   current_d = S_OVER;
         end
         S_SCORE: begin
            // Level is a single digit, so at most one carry into the tens.
            if (ones_sum >= 5'd10) begin
               if (tens_q >= 4'd9) begin
                  tens_d = 4'd9;
                  ones_d = 4'd9;
               end else begin
                  tens_d = tens_q + 4'd1;
                  ones_d = 4'(ones_sum - 5'd10);
               end
            end else begin
               ones_d = ones_sum[3:0];
            end
            if (level_in == 4'(MAX_LEVEL)) begin
               current_d = S_OVER;
            end else begin
               level_d   = level_in + 4'd1;
               current_d = S_RELEASE;
            end
         end
         default: current_d = S_OVER;
      endcase
   end

   always_ff @(posedge clock) begin
      if (start) begin
         _current  <= S_IDLE;
         count_q   <= 16'd0;
         level_in  <= 4'd1;
         tens_q    <= 4'd0;
         ones_q    <= 4'd0;
         pattern_q <= 10'd0;
         lfsr_q    <= 10'h2A5;
         led       <= 10'd0;
         point_msb <= 7'h40;
         point_lsb <= 7'h40;
         level_out <= 7'h79;
         splitter  <= 1'b1;
      end else begin
         _current  <= current_d;
         count_q   <= count_d;
         level_in  <= level_d;
         tens_q    <= tens_d;
         ones_q    <= ones_d;
         pattern_q <= pattern_d;
         lfsr_q    <= lfsr_next;
         // Outputs are registered from next-state values so they track the state exactly.
         led       <= (current_d == S_SHOW || current_d == S_INPUT) ? pattern_d : 10'd0;
         point_msb <= seg7(tens_d);
         point_lsb <= seg7(ones_d);
         level_out <= (level_d >= 4'd1 && level_d <= 4'd9) ? seg7(level_d) : 7'h7F;
         splitter  <= (current_d != S_OVER);
      end
   end

endmodule

// File: tb/tb_status.sv
// Randomized bench for the reaction-game core: a cycle-level game model predicts
// every output; a monitor compares DUT outputs against the queued predictions.
module tb_status;
   localparam int SHOW_C = 16;
   localparam int TBASE  = 256;
   localparam int TSTEP  = 16;
   localparam int MAXLVL = 9;

   logic       clock = 1'b0;
   logic       start = 1'b1;
   logic [9:0] switch = 10'd0;
   logic [9:0] led;
   logic [6:0] point_msb, point_lsb, level_out;
   logic       splitter;

   status dut (
      .clock(clock), .start(start), .switch(switch), .led(led),
      .point_msb(point_msb), .point_lsb(point_lsb), .level_out(level_out),
      .splitter(splitter)
   );

   always #5 clock = ~clock;

   typedef struct packed {
      logic [3:0] st;
      logic [9:0] led;
      logic [6:0] msb;
      logic [6:0] lsb;
      logic [6:0] lvl;
      logic       spl;
   } exp_t;

   exp_t exp_q[$];
   int checks = 0;
   int errors = 0;

   // Game model: phase codes 0 OVER .. 6 SCORE, score kept as a plain integer.
   int         m_state = 1;
   int         m_elapsed = 0;
   int         m_level = 1;
   int         m_score = 0;
   logic [9:0] m_pattern = 10'd0;
   logic [9:0] m_lfsr = 10'h2A5;

   function automatic logic [6:0] seg(input int d);
      case (d)
         0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
         4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
         8: return 7'h00;  9: return 7'h10;
         default: return 7'h7F;
      endcase
   endfunction

   function automatic int time_limit(input int lvl);
      int lim;
      lim = TBASE - (lvl - 1) * TSTEP;
      return (lim < 8) ? 8 : lim;
   endfunction

   task automatic model_step(input logic st, input logic [9:0] sw);
      logic [9:0] cur_lfsr;
      if (st) begin
         m_state = 1; m_elapsed = 0; m_level = 1; m_score = 0;
         m_pattern = 10'd0; m_lfsr = 10'h2A5;
         return;
      end
      cur_lfsr = m_lfsr;
      m_lfsr = 10'(((int'(m_lfsr) << 1) & 'h3FF) | (((int'(m_lfsr) >> 9) ^ (int'(m_lfsr) >> 6)) & 1));
      case (m_state)
         1: if (sw[9]) m_state = 2;
         2: if (sw == 10'd0) m_state = 3;
         3: begin
            m_pattern = (cur_lfsr == 10'd0) ? 10'h001 : cur_lfsr;
            m_elapsed = 0;
            m_state = 4;
         end
         4: begin
            m_elapsed++;
            if (m_elapsed == SHOW_C) begin m_elapsed = 0; m_state = 5; end
         end
         5: begin
            m_elapsed++;
            if ((sw & ~m_pattern) != 10'd0)        m_state = 0;
            else if (sw == m_pattern)              m_state = 6;
            else if (m_elapsed == time_limit(m_level)) m_state = 0;
         end
         6: begin
            m_score = (m_score + m_level > 99) ? 99 : m_score + m_level;
            if (m_level == MAXLVL) m_state = 0;
            else begin m_level++; m_state = 2; end
         end
         default: m_state = 0;
      endcase
   endtask

   function automatic exp_t predict();
      exp_t e;
      e.st  = 4'(m_state);
      e.led = (m_state == 4 || m_state == 5) ? m_pattern : 10'd0;
      e.msb = seg(m_score / 10);
      e.lsb = seg(m_score % 10);
      e.lvl = seg(m_level);
      e.spl = (m_state != 0);
      return e;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
      end
   endtask

   always @(posedge clock) begin : monitor
      exp_t e;
      #1;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk("state",     32'(dut._current), 32'(e.st));
         chk("led",       32'(led),          32'(e.led));
         chk("point_msb", 32'(point_msb),    32'(e.msb));
         chk("point_lsb", 32'(point_lsb),    32'(e.lsb));
         chk("level_out", 32'(level_out),    32'(e.lvl));
         chk("splitter",  32'(splitter),     32'(e.spl));
      end
   end

   task automatic tick(input logic st, input logic [9:0] sw);
      @(negedge clock);
      start  = st;
      switch = sw;
      model_step(st, sw);
      exp_q.push_back(predict());
   endtask

   // mode 0: win every level; 1: wrong switch at stop_lvl; 2: timeout at stop_lvl;
   // 3: restart mid-input at stop_lvl.
   task automatic play(input int mode, input int stop_lvl);
      int guard;
      int r;
      logic [9:0] sw;
      logic [9:0] outside;
      guard = 0;
      while (m_state != 0 && guard < 6000) begin
         sw = 10'd0;
         case (m_state)
            1: sw = ($urandom_range(0, 2) == 0) ? (10'($urandom) & 10'h1FF) : (10'h200 | 10'($urandom));
            2: sw = ($urandom_range(0, 2) == 0) ? 10'($urandom) : 10'd0;
            5: begin
               if (mode != 0 && m_level == stop_lvl) begin
                  if (mode == 1) begin
                     if (m_elapsed >= 2 && m_pattern != 10'h3FF) begin
                        outside = ~m_pattern;
                        r = $urandom_range(0, 9);
                        while (!outside[r]) r = $urandom_range(0, 9);
                        sw = m_pattern & 10'($urandom);
                        sw[r] = 1'b1;
                     end else if (m_elapsed >= 2) begin
                        sw = m_pattern;
                     end
                  end else if (mode == 2) begin
                     sw = m_pattern & (m_pattern - 10'd1) & 10'($urandom);
                  end else if (m_elapsed >= 3) begin
                     repeat (3) tick(1'b1, 10'($urandom));
                     return;
                  end
               end else begin
                  sw = ($urandom_range(0, 3) == 0) ? m_pattern : (m_pattern & 10'($urandom));
               end
            end
            default: sw = 10'($urandom);
         endcase
         tick(1'b0, sw);
         guard++;
      end
      if (guard >= 6000) begin
         checks++;
         errors++;
         $display("FAIL game_timeout: got no OVER after %0d cycles, expected OVER", guard);
      end
      repeat (4) tick(1'b0, 10'($urandom));
   endtask

   initial begin
      repeat (128) tick(1'b1, 10'($urandom));
      play(0, 0);
      tick(1'b1, 10'd0);
      play(1, $urandom_range(1, 9));
      tick(1'b1, 10'd0);
      play(2, 1);
      tick(1'b1, 10'd0);
      play(2, $urandom_range(2, 4));
      tick(1'b1, 10'd0);
      play(3, 2);
      play(0, 0);
      for (int g = 0; g < 4; g++) begin
         tick(1'b1, 10'd0);
         play($urandom_range(0, 1), $urandom_range(1, 9));
      end
      tick(1'b1, 10'd0);
      tick(1'b0, 10'd0);
      @(negedge clock);
      @(negedge clock);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
